// File: rtl/enc_pkg.sv
// rtl/enc_pkg.sv - shared state type, default widths and bit-count helper for enc8to3_seq
package enc_pkg;
   localparam int ENC_W  = 8;
   localparam int ENC_IW = $clog2(ENC_W);
   localparam int MAX_W  = 32;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   // True when exactly one bit of v is set; callers zero-extend narrower vectors.
   function automatic logic onehot_cnt_is1(input logic [MAX_W-1:0] v);
      return (v != '0) && ((v & (v - MAX_W'(1))) == '0);
   endfunction
endpackage

// File: rtl/pri_enc8.sv
// rtl/pri_enc8.sv - combinational find-first-set, direction selectable (LSB or MSB first)
module pri_enc8
   import enc_pkg::*;
#(
   parameter int W  = ENC_W,
   parameter int IW = $clog2(W)
) (
   input  logic [W-1:0]  vec,
   input  logic          msb_first,
   output logic [IW-1:0] idx
);

   // Later loop iterations override earlier ones, so scan toward the winning end.
   always_comb begin
      idx = '0;
      if (msb_first) begin
         for (int i = 0; i < W; i++) begin
            if (vec[i]) idx = IW'(i);
         end
      end else begin
         for (int i = W - 1; i >= 0; i--) begin
            if (vec[i]) idx = IW'(i);
         end
      end
   end

endmodule

// File: rtl/enc8to3_seq.sv
// rtl/enc8to3_seq.sv - sequential 8-to-3 encoder, one index per handshake
// ENC_MSB_FIRST_EN: when defined, indices are emitted highest set bit first.
module enc8to3_seq
   import enc_pkg::*;
#(
   parameter int W  = ENC_W,
   parameter int IW = $clog2(W)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [IW-1:0] out,
   output logic          out_last,
   output logic          err_zero,
   output logic          busy
);

   state_e         state_q, state_d;
   logic [W-1:0]   pending_q, pending_d;
   logic           err_zero_q, err_zero_d;
   logic [IW-1:0]  idx;
   logic           last;
   logic           msb_first;
   logic [W-1:0]   take_mask;

`ifdef ENC_MSB_FIRST_EN
   assign msb_first = 1'b1;
`else
   assign msb_first = 1'b0;
`endif

   pri_enc8 #(
      .W  (W),
      .IW (IW)
   ) u_pri_enc (
      .vec       (pending_q),
      .msb_first (msb_first),
      .idx       (idx)
   );

   assign last      = onehot_cnt_is1(MAX_W'(pending_q));
   assign take_mask = W'(1) << idx;

   always_comb begin
      state_d    = state_q;
      pending_d  = pending_q;
      err_zero_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               if (in != '0) begin
                  pending_d = in;
                  state_d   = BUSY;
               end else begin
                  err_zero_d = 1'b1;
               end
            end
         end
         BUSY: begin
            if (out_ready) begin
               pending_d = pending_q & ~take_mask;
               if (last) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         pending_q  <= '0;
         err_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         err_zero_q <= err_zero_d;
      end
   end

   // Everything visible downstream comes from registered state; pending is zero in IDLE.
   assign in_ready  = en & (state_q == IDLE);
   assign out_valid = (state_q == BUSY);
   assign busy      = (state_q == BUSY);
   assign out       = idx;
   assign out_last  = last;
   assign err_zero  = err_zero_q;

endmodule

// File: tb/tb_enc8to3_seq.sv
// tb/tb_enc8to3_seq.sv - randomized self-checking bench for enc8to3_seq against an index-list model
module tb_enc8to3_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_vec;
   logic       out_valid;
   logic       out_ready;
   logic [2:0] out_idx;
   logic       out_last;
   logic       err_zero;
   logic       busy;

   int n_total = 0;
   int n_bad   = 0;

   enc8to3_seq dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in        (in_vec),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out_idx),
      .out_last  (out_last),
      .err_zero  (err_zero),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: list of set-bit positions in emission order.
   function automatic void expect_list(input logic [7:0] v, output int q[$]);
      q = {};
      for (int i = 0; i < 8; i++) begin
         if ((v >> i) % 2 == 1) begin
`ifdef ENC_MSB_FIRST_EN
            q.push_front(i);
`else
            q.push_back(i);
`endif
         end
      end
   endfunction

   // Accept v, then drain its indices; the first index is stalled stall_first cycles,
   // later ones stall randomly with probability stall_pct percent.
   task automatic run_vec(input logic [7:0] v, input int stall_first, input int stall_pct);
      int q[$];
      int stalls;
      bit taken;
      expect_list(v, q);
      en       = 1'b1;
      in_vec   = v;
      in_valid = 1'b1;
      check("in_ready_idle", in_ready, 1);
      tick();
      in_valid = 1'b0;
      in_vec   = $urandom;
      if (q.size() == 0) begin
         check("err_zero_pulse", err_zero, 1);
         check("zero_busy", busy, 0);
         check("zero_out_valid", out_valid, 0);
         tick();
         check("err_zero_clear", err_zero, 0);
         return;
      end
      check("no_err_zero", err_zero, 0);
      for (int k = 0; k < q.size(); k++) begin
         stalls = 0;
         taken  = 0;
         while (!taken) begin
            if (k == 0 && stalls < stall_first) out_ready = 1'b0;
            else if (k == 0)                    out_ready = 1'b1;
            else out_ready = ($urandom_range(99) >= stall_pct);
            in_valid = $urandom_range(1);
            check("out_valid", out_valid, 1);
            check("out_idx", out_idx, q[k]);
            check("out_last", out_last, (k == q.size() - 1));
            check("busy", busy, 1);
            check("in_ready_busy", in_ready, 0);
            taken = out_ready;
            tick();
            stalls++;
            if (stalls > 200) begin
               check("drain_timeout", 0, 1);
               taken = 1;
            end
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("done_out_valid", out_valid, 0);
      check("done_busy", busy, 0);
      check("done_in_ready", in_ready, 1);
   endtask

   initial begin
      // T1 reset
      rst = 1'b1; en = 1'b1; in_valid = 1'b0; in_vec = '0; out_ready = 1'b0;
      #2;
      check("rst_out_valid", out_valid, 0);
      check("rst_out", out_idx, 0);
      check("rst_out_last", out_last, 0);
      check("rst_err_zero", err_zero, 0);
      check("rst_busy", busy, 0);
      check("rst_in_ready_en1", in_ready, 1);
      en = 1'b0;
      #1;
      check("rst_in_ready_en0", in_ready, 0);
      en = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();

      // T2 one-hot sweep
      for (int i = 0; i < 8; i++) run_vec(8'(1 << i), 0, 0);

      // T3 multi-hot
      run_vec(8'b1010_0110, 0, 0);

      // T4 stall three cycles on the first index
      run_vec(8'b0001_1000, 3, 0);

      // T5 zero vector, then en=0 blocks acceptance
      run_vec(8'h00, 0, 0);
      en = 1'b0; in_valid = 1'b1; in_vec = 8'h0F;
      #1;
      check("en0_in_ready", in_ready, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("en0_busy", busy, 0);
         check("en0_out_valid", out_valid, 0);
      end
      in_valid = 1'b0;
      en = 1'b1;

      // T6 reset mid-vector after two indices
      in_vec = 8'hFF; in_valid = 1'b1;
      tick();
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      tick();
      check("mid_out_valid_pre", out_valid, 1);
      out_ready = 1'b0;
      rst = 1'b1;
      #1;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_out_last", out_last, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      run_vec(8'h80, 0, 0);

      // Random vectors with random backpressure
      for (int n = 0; n < 60; n++) begin
         logic [7:0] v;
         v = ($urandom_range(9) == 0) ? 8'h00 : 8'($urandom);
         run_vec(v, $urandom_range(2), $urandom_range(60));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
